// File: rtl/sddr_port_arbiter_if.sv
// sddr_port_arbiter_if: requester and controller handshake bundle for the port arbiter
interface sddr_port_arbiter_if #(
    parameter int NUM_PORTS       = 2,
    parameter int ADDRESS_BITS    = 27,
    parameter int CMD_DATA_BITS   = 128,
    parameter int MAX_OUTSTANDING = 4
);
    logic [NUM_PORTS-1:0]               req_valid_i;
    logic [NUM_PORTS*ADDRESS_BITS-1:0]  req_address_i;
    logic [NUM_PORTS-1:0]               req_write_i;
    logic [NUM_PORTS*CMD_DATA_BITS-1:0] req_data_i;
    logic [NUM_PORTS-1:0]               req_ack_o;
    logic [NUM_PORTS-1:0]               rsp_ready_o;
    logic [CMD_DATA_BITS-1:0]           rsp_data_o;
    logic                               data_cmd_valid_o;
    logic [ADDRESS_BITS-1:0]            data_cmd_address_o;
    logic                               data_cmd_write_o;
    logic [CMD_DATA_BITS-1:0]           data_cmd_data_o;
    logic                               data_cmd_ack_i;
    logic                               data_rsp_ready_i;
    logic [CMD_DATA_BITS-1:0]           data_rsp_data_i;
    logic                               rsp_error_o;
    logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o;

    modport slave (
        input  req_valid_i, req_address_i, req_write_i, req_data_i,
        input  data_cmd_ack_i, data_rsp_ready_i, data_rsp_data_i,
        output req_ack_o, rsp_ready_o, rsp_data_o,
        output data_cmd_valid_o, data_cmd_address_o, data_cmd_write_o, data_cmd_data_o,
        output rsp_error_o, outstanding_o
    );

    modport master (
        output req_valid_i, req_address_i, req_write_i, req_data_i,
        output data_cmd_ack_i, data_rsp_ready_i, data_rsp_data_i,
        input  req_ack_o, rsp_ready_o, rsp_data_o,
        input  data_cmd_valid_o, data_cmd_address_o, data_cmd_write_o, data_cmd_data_o,
        input  rsp_error_o, outstanding_o
    );
endinterface

// File: rtl/sddr_port_arbiter.sv
// sddr_port_arbiter: round-robin arbiter funnelling N requesters into one controller command port with in-order read return
module sddr_port_arbiter #(
    parameter int NUM_PORTS       = 2,
    parameter int ADDRESS_BITS    = 27,
    parameter int CMD_DATA_BITS   = 128,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic cpu_clock_i,
    input logic reset_n_i,
    sddr_port_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_PORTS);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);

    typedef enum logic {ARB, ISSUE} state_t;

    state_t                   state_q;
    logic [IW-1:0]            last_grant_q;
    logic [IW-1:0]            cmd_id_q;
    logic [ADDRESS_BITS-1:0]  cmd_address_q;
    logic                     cmd_write_q;
    logic [CMD_DATA_BITS-1:0] cmd_data_q;
    logic [IW-1:0]            fifo_q [MAX_OUTSTANDING];
    logic [PW-1:0]            wr_ptr_q;
    logic [PW-1:0]            rd_ptr_q;
    logic [OW-1:0]            count_q;
    logic [OW-1:0]            count_d;
    logic [NUM_PORTS-1:0]     rsp_ready_q;
    logic [CMD_DATA_BITS-1:0] rsp_data_q;
    logic                     rsp_error_q;
    logic [IW-1:0]            winner;
    logic                     found;
    logic                     grant;
    logic                     push;
    logic                     pop;

    // Round-robin search starting just above the last granted port
    always_comb begin
        winner = last_grant_q;
        found  = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (!found && bus.req_valid_i[IW'((int'(last_grant_q) + k) % NUM_PORTS)]) begin
                winner = IW'((int'(last_grant_q) + k) % NUM_PORTS);
                found  = 1'b1;
            end
        end
    end

    // Acks are gated by reset so nothing is offered while the block is held in reset
    assign grant   = reset_n_i && state_q == ARB && count_q < MAX_CNT && found;
    assign push    = state_q == ISSUE && bus.data_cmd_ack_i && !cmd_write_q;
    assign pop     = bus.data_rsp_ready_i && count_q != '0;
    assign count_d = count_q + OW'(push) - OW'(pop);

    assign bus.req_ack_o          = grant ? NUM_PORTS'(1) << winner : '0;
    assign bus.data_cmd_valid_o   = state_q == ISSUE;
    assign bus.data_cmd_address_o = cmd_address_q;
    assign bus.data_cmd_write_o   = cmd_write_q;
    assign bus.data_cmd_data_o    = cmd_data_q;
    assign bus.rsp_ready_o        = rsp_ready_q;
    assign bus.rsp_data_o         = rsp_data_q;
    assign bus.rsp_error_o        = rsp_error_q;
    assign bus.outstanding_o      = count_q;

    // Arbitration FSM: capture the winner into the command register, hold it until the controller takes it
    always_ff @(posedge cpu_clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= ARB;
            last_grant_q  <= IW'(NUM_PORTS - 1);
            cmd_id_q      <= '0;
            cmd_address_q <= '0;
            cmd_write_q   <= 1'b0;
            cmd_data_q    <= '0;
        end else if (state_q == ARB) begin
            if (grant) begin
                state_q       <= ISSUE;
                last_grant_q  <= winner;
                cmd_id_q      <= winner;
                cmd_address_q <= bus.req_address_i[winner*ADDRESS_BITS +: ADDRESS_BITS];
                cmd_write_q   <= bus.req_write_i[winner];
                cmd_data_q    <= bus.req_data_i[winner*CMD_DATA_BITS +: CMD_DATA_BITS];
            end
        end else if (bus.data_cmd_ack_i) begin
            state_q <= ARB;
        end
    end

    // ID FIFO remembering which port owns each read still in flight
    always_ff @(posedge cpu_clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= cmd_id_q;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Route each returning read to the port at the FIFO head; flag responses nobody asked for
    always_ff @(posedge cpu_clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rsp_ready_q <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            rsp_ready_q <= pop ? NUM_PORTS'(1) << fifo_q[rd_ptr_q] : '0;
            if (pop) rsp_data_q <= bus.data_rsp_data_i;
            if (bus.data_rsp_ready_i && count_q == '0) rsp_error_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sddr_port_arbiter.sv
// tb_sddr_port_arbiter: directed and random stimulus checked against a queue-based reference model
module tb_sddr_port_arbiter;
    localparam int N  = 2;
    localparam int AB = 27;
    localparam int DB = 128;
    localparam int MO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    sddr_port_arbiter_if #(.NUM_PORTS(N), .ADDRESS_BITS(AB), .CMD_DATA_BITS(DB), .MAX_OUTSTANDING(MO)) bus();

    sddr_port_arbiter #(.NUM_PORTS(N), .ADDRESS_BITS(AB), .CMD_DATA_BITS(DB), .MAX_OUTSTANDING(MO)) dut (
        .cpu_clock_i(clk),
        .reset_n_i  (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state
    int             last_grant;
    bit             issuing;
    int             p_id;
    logic [AB-1:0]  p_addr;
    bit             p_write;
    logic [DB-1:0]  p_data;
    int             ids[$];
    logic [N-1:0]   exp_rsp;
    logic [DB-1:0]  exp_data;
    bit             exp_err;
    logic [N-1:0]   dut_log[$];

    task automatic check(input string tag, input logic [DB-1:0] got, input logic [DB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DB-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int pick();
        if (!rst_n || issuing || ids.size() >= MO) return -1;
        for (int k = 1; k <= N; k++)
            if (bus.req_valid_i[(last_grant + k) % N]) return (last_grant + k) % N;
        return -1;
    endfunction

    task automatic set_in(input logic [N-1:0] v, input logic [N-1:0] wr, input bit cack, input bit rsp, input logic [DB-1:0] rdata);
        bus.req_valid_i      = v;
        bus.req_write_i      = wr;
        bus.data_cmd_ack_i   = cack;
        bus.data_rsp_ready_i = rsp;
        bus.data_rsp_data_i  = rdata;
        for (int p = 0; p < N; p++) begin
            bus.req_address_i[p*AB +: AB] = AB'($urandom);
            bus.req_data_i[p*DB +: DB]    = rnd_data();
        end
    endtask

    task automatic model_reset();
        ids.delete();
        issuing    = 1'b0;
        last_grant = N - 1;
        exp_rsp    = '0;
        exp_data   = '0;
        exp_err    = 1'b0;
        p_id       = 0;
        p_addr     = '0;
        p_write    = 1'b0;
        p_data     = '0;
    endtask

    // one clock: check combinational outputs, advance model across the edge, check registered outputs
    task automatic cycle();
        int w;
        logic [N-1:0] exp_ack;
        #1;
        w = pick();
        exp_ack = (w < 0) ? '0 : N'(1) << w;
        check("req_ack", DB'(bus.req_ack_o), DB'(exp_ack));
        if (bus.req_ack_o != '0) dut_log.push_back(bus.req_ack_o);
        if (issuing) begin
            check("cmd_address", DB'(bus.data_cmd_address_o), DB'(p_addr));
            check("cmd_write", DB'(bus.data_cmd_write_o), DB'(p_write));
            check("cmd_data", bus.data_cmd_data_o, p_data);
        end
        if (bus.data_rsp_ready_i && ids.size() > 0) begin
            exp_rsp  = N'(1) << ids.pop_front();
            exp_data = bus.data_rsp_data_i;
        end else begin
            exp_rsp = '0;
            if (bus.data_rsp_ready_i) exp_err = 1'b1;
        end
        if (issuing) begin
            if (bus.data_cmd_ack_i) begin
                issuing = 1'b0;
                if (!p_write) ids.push_back(p_id);
            end
        end else if (w >= 0) begin
            issuing    = 1'b1;
            p_id       = w;
            last_grant = w;
            p_addr     = bus.req_address_i[w*AB +: AB];
            p_write    = bus.req_write_i[w];
            p_data     = bus.req_data_i[w*DB +: DB];
        end
        @(negedge clk);
        check("cmd_valid", DB'(bus.data_cmd_valid_o), DB'(issuing));
        check("outstanding", DB'(bus.outstanding_o), DB'(ids.size()));
        check("rsp_ready", DB'(bus.rsp_ready_o), DB'(exp_rsp));
        check("rsp_data", bus.rsp_data_o, exp_data);
        check("rsp_error", DB'(bus.rsp_error_o), DB'(exp_err));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_ack", DB'(bus.req_ack_o), '0);
        check("rst_cmd_valid", DB'(bus.data_cmd_valid_o), '0);
        check("rst_outstanding", DB'(bus.outstanding_o), '0);
        check("rst_rsp_ready", DB'(bus.rsp_ready_o), '0);
        check("rst_rsp_data", bus.rsp_data_o, '0);
        check("rst_rsp_error", DB'(bus.rsp_error_o), '0);
        check("rst_cmd_address", DB'(bus.data_cmd_address_o), '0);
        check("rst_cmd_data", bus.data_cmd_data_o, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int vcnt;
        set_in('0, '0, 1'b0, 1'b0, '0);
        do_reset();

        // both ports reading back to back until the FIFO fills
        set_in(2'b11, 2'b00, 1'b1, 1'b0, '0);
        dut_log.delete();
        repeat (10) cycle();
        check("grant_count", DB'(dut_log.size()), DB'(4));
        for (int i = 0; i < 4 && i < dut_log.size(); i++) check("grant_order", DB'(dut_log[i]), DB'(N'(1) << (i % 2)));
        check("full_outstanding", DB'(bus.outstanding_o), DB'(4));
        check("full_no_ack", DB'(bus.req_ack_o), '0);

        // one response while full, then arbitration resumes
        set_in(2'b11, 2'b00, 1'b1, 1'b1, {16{8'hA5}});
        cycle();
        check("rsp_a5_ready", DB'(bus.rsp_ready_o), DB'(2'b01));
        check("rsp_a5_data", bus.rsp_data_o, {16{8'hA5}});
        check("rsp_a5_outstanding", DB'(bus.outstanding_o), DB'(3));
        set_in(2'b11, 2'b00, 1'b0, 1'b0, '0);
        #1;
        check("regrant", DB'(bus.req_ack_o), DB'(2'b01));
        cycle();

        // push and pop in the same cycle
        set_in(2'b00, 2'b00, 1'b1, 1'b1, rnd_data());
        cycle();
        check("pushpop_outstanding", DB'(bus.outstanding_o), DB'(3));
        check("pushpop_route", DB'(bus.rsp_ready_o), DB'(2'b10));

        // write from port 1 stalled by the controller
        set_in(2'b10, 2'b10, 1'b0, 1'b0, '0);
        cycle();
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.data_cmd_valid_o) vcnt++;
            set_in(2'b00, 2'b00, i == 5, 1'b0, '0);
            cycle();
        end
        check("write_valid_cycles", DB'(vcnt), DB'(6));
        check("write_no_push", DB'(bus.outstanding_o), DB'(3));

        // fill to full, confirm blocking, then drain in order
        set_in(2'b01, 2'b00, 1'b1, 1'b0, '0);
        repeat (2) cycle();
        set_in(2'b11, 2'b01, 1'b0, 1'b0, '0);
        cycle();
        check("full_block", DB'(bus.req_ack_o), '0);
        for (int i = 0; i < 4; i++) begin
            set_in(2'b00, 2'b00, 1'b0, 1'b1, rnd_data());
            cycle();
        end
        check("drained", DB'(bus.outstanding_o), '0);

        // response with nothing outstanding
        set_in(2'b00, 2'b00, 1'b0, 1'b1, rnd_data());
        cycle();
        set_in(2'b00, 2'b00, 1'b0, 1'b0, '0);
        repeat (3) cycle();
        check("error_sticky", DB'(bus.rsp_error_o), DB'(1));
        check("error_no_rsp", DB'(bus.rsp_ready_o), '0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            set_in(N'($urandom), N'($urandom), 1'($urandom), $urandom_range(0, 2) == 0, rnd_data());
            cycle();
        end

        // reset while a read is being issued with two reads in flight
        do_reset();
        set_in(2'b01, 2'b00, 1'b1, 1'b0, '0);
        repeat (2) cycle();
        set_in(2'b10, 2'b00, 1'b1, 1'b0, '0);
        repeat (2) cycle();
        set_in(2'b01, 2'b00, 1'b0, 1'b0, '0);
        cycle();
        check("pre_reset_outstanding", DB'(bus.outstanding_o), DB'(2));
        check("pre_reset_issue", DB'(bus.data_cmd_valid_o), DB'(1));
        do_reset();
        set_in(2'b11, 2'b00, 1'b1, 1'b0, '0);
        #1;
        check("post_reset_first_grant", DB'(bus.req_ack_o), DB'(2'b01));
        repeat (2) cycle();
        set_in(2'b00, 2'b00, 1'b0, 1'b1, rnd_data());
        cycle();
        set_in(2'b00, 2'b00, 1'b0, 1'b1, rnd_data());
        cycle();
        check("post_reset_error", DB'(bus.rsp_error_o), DB'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
